// File: rtl/issue_pkg.sv
// Shared RV32I decode definitions for the issue stage: opcodes, immediate
// formats, the decoded-packet struct and the decode function.
package issue_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;
    logic [31:0] imm;
  } dec_pkt_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic dec_pkt_t decode(input logic [31:0] instr);
    dec_pkt_t  d;
    imm_type_e t;
    d        = '0;
    t        = IMM_NONE;
    d.opcode = instr[6:0];
    d.funct3 = instr[14:12];
    d.funct7 = instr[31:25];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.rd     = instr[11:7];
    case (instr[6:0])
      OP_R: begin
        d.uses_rs1  = 1'b1;
        d.uses_rs2  = 1'b1;
        d.writes_rd = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        d.uses_rs1  = 1'b1;
        d.writes_rd = 1'b1;
        t           = IMM_I;
      end
      OP_STORE: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
        t          = IMM_S;
      end
      OP_BRANCH: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
        t          = IMM_B;
      end
      OP_JAL: begin
        d.writes_rd = 1'b1;
        t           = IMM_J;
      end
      OP_LUI, OP_AUIPC: begin
        d.writes_rd = 1'b1;
        t           = IMM_U;
      end
      default: d.illegal = 1'b1;
    endcase
    d.imm = gen_imm(instr, t);
    return d;
  endfunction

endpackage

// File: rtl/issue_if.sv
// Handshake bundle around the issue stage: fetch input, register-file
// address outputs, execute packet output, writeback retirement and flush.
interface issue_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) ();

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;

  logic [RA_W-1:0] rf_rs1;
  logic [RA_W-1:0] rf_rs2;

  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [RA_W-1:0] out_rd;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  logic            wb_valid;
  logic [RA_W-1:0] wb_rd;
  logic            flush;

  // master: the issue stage itself
  modport master (
    input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
    output in_ready, rf_rs1, rf_rs2, out_valid, out_opcode, out_funct3,
           out_funct7, out_rd, out_imm, out_pc, out_illegal
  );

  modport slave (
    output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, rf_rs1, rf_rs2, out_valid, out_opcode, out_funct3,
           out_funct7, out_rd, out_imm, out_pc, out_illegal
  );

endinterface

// File: rtl/issue_scoreboard.sv
// Busy-bit scoreboard with set/clear/flush and RAW/WAW hazard query.
// ISSUE_WB_BYPASS_EN: hazard sees busy bits already cleared by this cycle's writeback.
module issue_scoreboard #(
  parameter int RA_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 set_en,
  input  logic [RA_W-1:0]      set_idx,
  input  logic                 clr_en,
  input  logic [RA_W-1:0]      clr_idx,
  input  logic                 rs1_en,
  input  logic [RA_W-1:0]      rs1,
  input  logic                 rs2_en,
  input  logic [RA_W-1:0]      rs2,
  input  logic                 rd_en,
  input  logic [RA_W-1:0]      rd,
  output logic                 hazard,
  output logic [(1<<RA_W)-1:0] busy
);

  localparam int NREG = 1 << RA_W;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // x0 is excluded at the set side, so its bit can never become busy
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_idx != '0)) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // set is applied after clear so a same-index collision leaves the bit busy
  always_comb begin
    busy_d = (busy_q & ~clr_mask) | set_mask;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

`ifdef ISSUE_WB_BYPASS_EN
  assign busy_eff = busy_q & ~clr_mask;
`else
  assign busy_eff = busy_q;
`endif

  assign hazard = (rs1_en && busy_eff[rs1]) ||
                  (rs2_en && busy_eff[rs2]) ||
                  (rd_en  && busy_eff[rd]);

  assign busy = busy_q;

endmodule

// File: rtl/issue_stage.sv
// RV32I decode/issue stage: input slot, scoreboard hazard check, output packet
// aligned with registered register-file reads. ISSUE_WB_BYPASS_EN selects writeback bypass.
module issue_stage
  import issue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic     clk,
  input logic     reset,
  issue_if.master bus
);

  logic            slot_valid;
  logic [XLEN-1:0] slot_instr;
  logic [XLEN-1:0] slot_pc;
  dec_pkt_t        dec;

  logic            hazard;
  logic            issue;
  logic            accept;
  logic            stall;
  logic [RA_W-1:0] src1;
  logic [RA_W-1:0] src2;

  logic            out_valid_q;
  logic [6:0]      out_opcode_q;
  logic [2:0]      out_funct3_q;
  logic [6:0]      out_funct7_q;
  logic [RA_W-1:0] out_rd_q;
  logic [XLEN-1:0] out_imm_q;
  logic [XLEN-1:0] out_pc_q;
  logic            out_illegal_q;
  logic [RA_W-1:0] out_rs1_q;
  logic [RA_W-1:0] out_rs2_q;

  always_comb dec = decode(slot_instr);

  assign src1   = (slot_valid && dec.uses_rs1) ? dec.rs1 : '0;
  assign src2   = (slot_valid && dec.uses_rs2) ? dec.rs2 : '0;
  assign stall  = out_valid_q && !bus.out_ready;
  assign issue  = slot_valid && !hazard && !stall;
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready = !reset && (!slot_valid || issue);

  // while execute stalls, re-present the held sources so the RF data stays put
  assign bus.rf_rs1 = stall ? out_rs1_q : src1;
  assign bus.rf_rs2 = stall ? out_rs2_q : src2;

  issue_scoreboard #(.RA_W(RA_W)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.flush),
    .set_en  (issue && dec.writes_rd),
    .set_idx (dec.rd),
    .clr_en  (bus.wb_valid),
    .clr_idx (bus.wb_rd),
    .rs1_en  (slot_valid && dec.uses_rs1),
    .rs1     (dec.rs1),
    .rs2_en  (slot_valid && dec.uses_rs2),
    .rs2     (dec.rs2),
    .rd_en   (slot_valid && dec.writes_rd),
    .rd      (dec.rd),
    .hazard  (hazard),
    .busy    ()
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_instr <= '0;
      slot_pc    <= '0;
    end else if (bus.flush) begin
      slot_valid <= 1'b0;
    end else if (accept) begin
      slot_valid <= 1'b1;
      slot_instr <= bus.in_instr;
      slot_pc    <= bus.in_pc;
    end else if (issue) begin
      slot_valid <= 1'b0;
    end
  end

  // out_rd is zero for instructions that do not write a register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_opcode_q  <= '0;
      out_funct3_q  <= '0;
      out_funct7_q  <= '0;
      out_rd_q      <= '0;
      out_imm_q     <= '0;
      out_pc_q      <= '0;
      out_illegal_q <= 1'b0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (issue) begin
      out_valid_q   <= 1'b1;
      out_opcode_q  <= dec.opcode;
      out_funct3_q  <= dec.funct3;
      out_funct7_q  <= dec.funct7;
      out_rd_q      <= dec.writes_rd ? dec.rd : '0;
      out_imm_q     <= dec.imm;
      out_pc_q      <= slot_pc;
      out_illegal_q <= dec.illegal;
      out_rs1_q     <= src1;
      out_rs2_q     <= src2;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_opcode  = out_opcode_q;
  assign bus.out_funct3  = out_funct3_q;
  assign bus.out_funct7  = out_funct7_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed timing checks plus a packet
// scoreboard fed from accepted fetches and drained on execute handshakes.
module tb_issue_stage;

  localparam logic [31:0] ADDI_X1  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD_X3   = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] ADDI_X6  = 32'h00120313; // addi x6,x4,1
  localparam logic [31:0] SW_X2    = 32'hFE20AE23; // sw   x2,-4(x1)
  localparam logic [31:0] JAL_NEG  = 32'hFFDFF06F; // jal  x0,-4
  localparam logic [31:0] ILL      = 32'h0000007F;
  localparam logic [31:0] ADDI_X5  = 32'h00100293; // addi x5,x0,1

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_if #(.XLEN(32), .RA_W(5)) bus ();

  issue_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [86:0] sb[$];
  logic [31:0] pc = 32'h0000_1000;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: {opcode, funct3, funct7, rd, illegal, imm, pc}
  function automatic logic [86:0] model(input logic [31:0] i, input logic [31:0] p);
    logic [31:0] imm;
    logic        wr;
    logic        ill;
    logic        s;
    imm = '0;
    wr  = 1'b0;
    ill = 1'b0;
    s   = i[31];
    case (i[6:0])
      7'h33: wr = 1'b1;
      7'h13, 7'h03, 7'h67: begin wr = 1'b1; imm = {{20{s}}, i[31:20]}; end
      7'h23: imm = {{20{s}}, i[31:25], i[11:7]};
      7'h63: imm = {{20{s}}, i[7], i[30:25], i[11:8], 1'b0};
      7'h6F: begin wr = 1'b1; imm = {{12{s}}, i[19:12], i[20], i[30:21], 1'b0}; end
      7'h37, 7'h17: begin wr = 1'b1; imm = {i[31:12], 12'h000}; end
      default: ill = 1'b1;
    endcase
    return {i[6:0], i[14:12], i[31:25], (wr ? i[11:7] : 5'd0), ill, imm, p};
  endfunction

  function automatic logic [86:0] observed();
    return {bus.out_opcode, bus.out_funct3, bus.out_funct7, bus.out_rd,
            bus.out_illegal, bus.out_imm, bus.out_pc};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.flush) begin
        sb.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          check("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) check("pkt", observed(), sb.pop_front());
        end
        if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_instr, bus.in_pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction; returns just after the accepting edge.
  task automatic send(input logic [31:0] instr);
    int n;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    #1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_accept", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    pc           = pc + 4;
  endtask

  task automatic wb(input logic [4:0] idx);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = idx;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.flush     = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_rf_rs1", bus.rf_rs1, 0);
    check("post_rst_out_imm", bus.out_imm, 0);
    check("post_rst_busy", dut.u_sb.busy_q, 0);

    // addi x1: out_valid two edges after the offer cycle
    bus.out_ready = 1'b1;
    send(ADDI_X1);
    check("addi_not_yet", bus.out_valid, 0);
    check("addi_rf_rs1", bus.rf_rs1, 0);
    tick();
    check("addi_out_valid", bus.out_valid, 1);
    check("addi_rd", bus.out_rd, 1);
    check("addi_imm", bus.out_imm, 5);
    check("addi_busy", dut.u_sb.busy_q, 32'h2);

    // add x3,x1,x2 stalls on busy x1 until writeback
    send(ADD_X3);
    for (int k = 0; k < 3; k++) begin
      check("raw_stall_valid", bus.out_valid, 0);
      check("raw_stall_ready", bus.in_ready, 0);
      tick();
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    tick();
    bus.wb_valid = 1'b0;
`ifdef ISSUE_WB_BYPASS_EN
    check("raw_bypass_issue", bus.out_valid, 1);
`else
    check("raw_wb_wait", bus.out_valid, 0);
    tick();
    check("raw_issue", bus.out_valid, 1);
`endif
    check("raw_rd", bus.out_rd, 3);
    check("raw_busy", dut.u_sb.busy_q, 32'h8);
    wb(5'd3);

    // execute stall holds packet and RF address; queued sw waits behind it
    bus.out_ready = 1'b0;
    send(ADDI_X6);
    send(SW_X2);
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_rf_rs1", bus.rf_rs1, 4);
      check("stall_imm", bus.out_imm, 1);
      check("stall_rd", bus.out_rd, 6);
      check("stall_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_rf_rs1", bus.rf_rs1, 1);
    check("release_rf_rs2", bus.rf_rs2, 2);
    tick();
    check("sw_valid", bus.out_valid, 1);
    check("sw_imm", bus.out_imm, 32'hFFFF_FFFC);
    check("sw_rd", bus.out_rd, 0);
    check("sw_busy", dut.u_sb.busy_q, 32'h40);
    tick();
    wb(5'd6);

    // jal and illegal opcode back to back
    send(JAL_NEG);
    send(ILL);
    check("jal_imm", bus.out_imm, 32'hFFFF_FFFC);
    check("jal_imm_bit0", bus.out_imm[0], 0);
    tick();
    check("ill_flag", bus.out_illegal, 1);
    check("ill_rd", bus.out_rd, 0);
    tick();
    check("jal_ill_busy", dut.u_sb.busy_q, 0);

    // writeback clear and issue set of x5 in the same cycle
    send(ADDI_X5);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    tick();
    bus.wb_valid = 1'b0;
    check("set_wins", dut.u_sb.busy_q, 32'h20);
    wb(5'd5);
    check("x5_cleared", dut.u_sb.busy_q, 0);

    // flush a stalled packet plus a hazarded slot
    bus.out_ready = 1'b0;
    send(ADDI_X1);
    send(ADD_X3);
    tick();
    check("pre_flush_valid", bus.out_valid, 1);
    check("pre_flush_busy", dut.u_sb.busy_q, 32'h2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_valid", bus.out_valid, 0);
    check("flush_busy", dut.u_sb.busy_q, 0);
    check("flush_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    send(ADD_X3);
    tick();
    check("post_flush_issue", bus.out_valid, 1);
    check("post_flush_rd", bus.out_rd, 3);
    tick();
    wb(5'd3);

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
